decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised, registered RV decode stage; successor to the single-opcode combinational decoder.
- Decodes all base integer formats (R/I/S/B/U/J) into register indices, a sign-extended immediate, an op class and a write enable.
- Sits between the fetch stage (IF) and the execute stage (EX), with a valid/ready handshake on both sides, one pipeline register, and a flush input.

Parameters:
- XLEN, 64, datapath width; immediate and PC width. Legal values: 32 or 64.
- RESET_PC, 0, value loaded into out_pc at reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  discard the held and incoming instruction
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  decode_stage can accept
- in_inst  in  32  instruction word
- in_pc  in  XLEN  PC of in_inst
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EX accepts the bundle
- out_pc  out  XLEN  registered PC
- out_rs1  out  5  inst[19:15]; 0 for U/J formats
- out_rs2  out  5  inst[24:20]; 0 unless R/S/B format
- out_rd  out  5  inst[11:7]; 0 when out_wen=0
- out_wen  out  1  rd write enable; 0 for S/B formats and when rd=0
- out_imm  out  XLEN  sign-extended immediate; 0 for R format
- out_funct3  out  3  inst[14:12]
- out_funct7b5  out  1  inst[30]
- out_class  out  4  0 OP_IMM, 1 OP, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 SYSTEM, 10 OP_IMM_32, 11 OP_32, 15 OTHER
- out_illegal  out  1  see Optional Feature

Behaviour:
- Reset: asynchronous. out_valid=0, out_pc=RESET_PC, all other outputs 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A transfer occurs on a rising clk edge when in_valid && in_ready.
  - Latency: 1 cycle from transfer to out_valid.
- Register update priority, highest first:
  1. flush: out_valid<=0; data registers hold. Any instruction offered in the same cycle is dropped. in_ready is not gated by flush.
  2. Transfer: all outputs are loaded from the decode of in_inst/in_pc; out_valid<=1.
  3. out_valid && out_ready with no new transfer: out_valid<=0.
  4. Otherwise all registers hold. While out_valid && !out_ready, outputs are stable.
- Back-to-back: a transfer and an EX accept in the same cycle give one bundle per cycle with no bubble.
- Immediate decode by opcode inst[6:0]:
  - I format: 0010011, 0000011, 1100111, 1110011, 0011011. imm = sext(inst[31:20]).
  - S format: 0100011. imm = sext({inst[31:25], inst[11:7]}).
  - B format: 1100011. imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U format: 0110111, 0010111. imm = sext({inst[31:12], 12'b0}); upper bits are sign-extended when XLEN=64.
  - J format: 1101111. imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - R format: 0110011, 0111011. imm = 0.
  - All sign extension fills to XLEN from inst[31].
- Classes 10/11 (OP_IMM_32, OP_32) exist only when XLEN=64. When XLEN=32, opcodes 0011011/0111011 decode as OTHER.
- Opcodes not listed above give class 15, wen=0, imm=0, rs1=rs2=rd=0.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- When defined, out_illegal is registered with the bundle and set when any of the following holds:
  - inst[1:0] != 2'b11;
  - class is OTHER;
  - class is OP or OP_32 and inst[31:25] is not 0000000 or 0100000.
  When out_illegal is set, out_wen is forced to 0.
- When not defined, out_illegal is constant 0 and no check logic is generated.

Test Plan:
- Reset mid-stream: assert rst while out_valid=1 -> immediately out_valid=0, out_pc=RESET_PC, out_imm=0.
- addi x1,x2,-1 (0xfff10093), XLEN=64 -> next cycle: class 0, rs1=2, rd=1, wen=1, imm=0xFFFF_FFFF_FFFF_FFFF.
- Three-instruction stream, no stalls:
  - sw x5,8(x2) (0x00512423) -> class 3, rs1=2, rs2=5, wen=0, imm=8.
  - beq x0,x0,-4 (0xfe000ee3) -> class 4, imm=-4.
  - jal x1,2048 (0x001000ef) -> class 7, rd=1, imm=0x800.
  - All three are delivered on consecutive cycles.
- Backpressure: present lui x5,0x12345 (0x123452b7) with out_ready=0 for 3 cycles -> in_ready=0, outputs stable with imm=0x12345000; release out_ready -> next instruction accepted in the same cycle.
- Flush: flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0; the offered instruction never appears on the outputs.
- With DECODE_ILLEGAL_EN: inst 0x00000000 -> out_illegal=1, wen=0. Without the macro: out_illegal=0.

Source files
------------

// File: rtl/decode_stage.sv
// Registered RV base-integer decode stage between IF and EX, with valid/ready on both sides and a flush input.
// Optional illegal-instruction detection is compiled in with `define DECODE_ILLEGAL_EN.
module decode_stage #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [3:0]      out_class,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam logic [3:0] CLS_OP_IMM    = 4'd0;
    localparam logic [3:0] CLS_OP        = 4'd1;
    localparam logic [3:0] CLS_LOAD      = 4'd2;
    localparam logic [3:0] CLS_STORE     = 4'd3;
    localparam logic [3:0] CLS_BRANCH    = 4'd4;
    localparam logic [3:0] CLS_LUI       = 4'd5;
    localparam logic [3:0] CLS_AUIPC     = 4'd6;
    localparam logic [3:0] CLS_JAL       = 4'd7;
    localparam logic [3:0] CLS_JALR      = 4'd8;
    localparam logic [3:0] CLS_SYSTEM    = 4'd9;
    localparam logic [3:0] CLS_OP_IMM_32 = 4'd10;
    localparam logic [3:0] CLS_OP_32     = 4'd11;
    localparam logic [3:0] CLS_OTHER     = 4'd15;

    localparam bit HAS_W_OPS = (XLEN == 64);

    logic               valid_q, valid_d;
    logic [XLEN-1:0]    pc_q;
    logic [4:0]         rs1_q, rs2_q, rd_q;
    logic               wen_q;
    logic [XLEN-1:0]    imm_q;
    logic [2:0]         funct3_q;
    logic               funct7b5_q;
    logic [3:0]         class_q;

    logic [3:0]         class_d;
    logic               use_rs1, use_rs2, has_rd;
    logic signed [31:0] imm32;
    logic               illegal_d;
    logic               wen_d;
    logic [4:0]         rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0]    imm_d;
    logic               xfer, load_en;

    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Opcode -> class, operand usage and the 32-bit immediate before widening.
    always_comb begin
        class_d = CLS_OTHER;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        has_rd  = 1'b0;
        imm32   = '0;
        case (in_inst[6:0])
            OPC_OP_IMM: begin class_d = CLS_OP_IMM; use_rs1 = 1'b1; has_rd = 1'b1; imm32 = imm_i; end
            OPC_OP:     begin class_d = CLS_OP;     use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b1; end
            OPC_LOAD:   begin class_d = CLS_LOAD;   use_rs1 = 1'b1; has_rd = 1'b1; imm32 = imm_i; end
            OPC_STORE:  begin class_d = CLS_STORE;  use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_s; end
            OPC_BRANCH: begin class_d = CLS_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_b; end
            OPC_LUI:    begin class_d = CLS_LUI;    has_rd = 1'b1; imm32 = imm_u; end
            OPC_AUIPC:  begin class_d = CLS_AUIPC;  has_rd = 1'b1; imm32 = imm_u; end
            OPC_JAL:    begin class_d = CLS_JAL;    has_rd = 1'b1; imm32 = imm_j; end
            OPC_JALR:   begin class_d = CLS_JALR;   use_rs1 = 1'b1; has_rd = 1'b1; imm32 = imm_i; end
            OPC_SYSTEM: begin class_d = CLS_SYSTEM; use_rs1 = 1'b1; has_rd = 1'b1; imm32 = imm_i; end
            OPC_OP_IMM_32: begin
                if (HAS_W_OPS) begin
                    class_d = CLS_OP_IMM_32; use_rs1 = 1'b1; has_rd = 1'b1; imm32 = imm_i;
                end
            end
            OPC_OP_32: begin
                if (HAS_W_OPS) begin
                    class_d = CLS_OP_32; use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // imm32 is signed, so the size cast sign-extends from inst[31].
    assign imm_d = XLEN'(imm32);
    assign wen_d = has_rd && (in_inst[11:7] != 5'd0) && !illegal_d;
    assign rd_d  = wen_d ? in_inst[11:7] : 5'd0;
    assign rs1_d = use_rs1 ? in_inst[19:15] : 5'd0;
    assign rs2_d = use_rs2 ? in_inst[24:20] : 5'd0;

    assign in_ready = !valid_q || out_ready;
    assign xfer     = in_valid && in_ready;
    assign load_en  = xfer && !flush;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (xfer) begin
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Bundle registers only move on an accepted, unflushed transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            imm_q      <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            class_q    <= '0;
        end else if (load_en) begin
            pc_q       <= in_pc;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            wen_q      <= wen_d;
            imm_q      <= imm_d;
            funct3_q   <= in_inst[14:12];
            funct7b5_q <= in_inst[30];
            class_q    <= class_d;
        end
    end

`ifdef DECODE_ILLEGAL_EN
    logic illegal_q;

    always_comb begin
        illegal_d = (in_inst[1:0] != 2'b11) || (class_d == CLS_OTHER);
        if (((class_d == CLS_OP) || (class_d == CLS_OP_32)) &&
            !((in_inst[31:25] == 7'b0000000) || (in_inst[31:25] == 7'b0100000))) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (load_en) begin
            illegal_q <= illegal_d;
        end
    end

    assign out_illegal = illegal_q;
`else
    assign illegal_d   = 1'b0;
    assign out_illegal = 1'b0;
`endif

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_rd       = rd_q;
    assign out_wen      = wen_q;
    assign out_imm      = imm_q;
    assign out_funct3   = funct3_q;
    assign out_funct7b5 = funct7b5_q;
    assign out_class    = class_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage at XLEN=64: expected bundles are queued at each transfer
// and compared when EX accepts them; illegal expectations follow DECODE_ILLEGAL_EN.
module tb_decode_stage;

    localparam int          XLEN = 64;
    localparam logic [63:0] RPC  = 64'h0000_0000_8000_0000;
`ifdef DECODE_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] imm;
        logic [2:0]  f3;
        logic        f7b5;
        logic [3:0]  cls;
        logic        ill;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_inst = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic            out_wen;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_funct3;
    logic            out_funct7b5;
    logic [3:0]      out_class;
    logic            out_illegal;

    int   tests_run = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t act;

    decode_stage #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_wen(out_wen),
        .out_imm(out_imm), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_class(out_class), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign act = {out_pc, out_rs1, out_rs2, out_rd, out_wen, out_imm,
                  out_funct3, out_funct7b5, out_class, out_illegal};

    function automatic exp_t mk(input logic [63:0] pc, input logic [3:0] cls,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic wen, input logic [63:0] imm, input logic [2:0] f3,
                                input logic f7b5, input logic ill);
        exp_t e;
        e.pc = pc; e.cls = cls; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.wen = wen;
        e.imm = imm; e.f3 = f3; e.f7b5 = f7b5; e.ill = ill;
        return e;
    endfunction

    // Scoreboard: every bundle EX accepts must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            tests_run++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL bundle_unexpected: got pc=%h class=%0d, required no bundle", out_pc, out_class);
            end else begin
                e = q.pop_front();
                if (act !== e) begin
                    fails++;
                    $display("FAIL bundle pc=%h: got %h, required %h", e.pc, act, e);
                end
            end
        end
    end

    // Offers one instruction; releases EX backpressure if IF is stalled. Returns at posedge+1 after the transfer.
    task automatic send(input logic [31:0] inst, input logic [63:0] pc, input exp_t e);
        bit ok = 1'b0;
        in_valid = 1'b1; in_inst = inst; in_pc = pc;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        tests_run++;
        if (!ok) begin
            fails++;
            $display("FAIL send_timeout pc=%h: got in_ready=0, required 1 within 8 cycles", pc);
        end else begin
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, out_pc, out_imm, out_rd, out_wen, out_class, out_illegal} !==
            {1'b0, RPC, 64'd0, 5'd0, 1'b0, 4'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: got v=%b pc=%h imm=%h, required v=0 pc=%h imm=0", out_valid, out_pc, out_imm, RPC);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({out_valid, in_ready, out_pc} !== {1'b0, 1'b1, RPC}) begin
            fails++;
            $display("FAIL reset_idle: got v=%b rdy=%b pc=%h, required v=0 rdy=1 pc=%h", out_valid, in_ready, out_pc, RPC);
        end
    endtask

    task automatic test_single_addi();
        out_ready = 1'b1;
        send(32'hfff10093, 64'h1000, mk(64'h1000, 4'd0, 5'd2, 5'd0, 5'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b1, 1'b0));
        tests_run++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL addi_latency: got out_valid=%b, required 1", out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int c0;
        out_ready = 1'b1;
        c0 = cyc;
        send(32'h00512423, 64'h1100, mk(64'h1100, 4'd3, 5'd2, 5'd5, 5'd0, 1'b0, 64'd8, 3'd2, 1'b0, 1'b0));
        send(32'hfe000ee3, 64'h1104, mk(64'h1104, 4'd4, 5'd0, 5'd0, 5'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd0, 1'b1, 1'b0));
        tests_run++;
        if ({out_valid, out_pc} !== {1'b1, 64'h1104}) begin
            fails++;
            $display("FAIL b2b_second: got v=%b pc=%h, required v=1 pc=1104", out_valid, out_pc);
        end
        send(32'h001000ef, 64'h1108, mk(64'h1108, 4'd7, 5'd0, 5'd0, 5'd1, 1'b1, 64'h800, 3'd0, 1'b0, 1'b0));
        tests_run++;
        if (cyc - c0 !== 3) begin
            fails++;
            $display("FAIL b2b_cycles: got %0d cycles for 3 transfers, required 3", cyc - c0);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(32'h123452b7, 64'h2000, mk(64'h2000, 4'd5, 5'd0, 5'd0, 5'd5, 1'b1, 64'h1234_5000, 3'd5, 1'b0, 1'b0));
        in_valid = 1'b1; in_inst = 32'h002081b3; in_pc = 64'h2004;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({in_ready, out_valid, out_imm, out_rd, out_pc} !== {1'b0, 1'b1, 64'h1234_5000, 5'd5, 64'h2000}) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got rdy=%b v=%b imm=%h rd=%0d, required rdy=0 v=1 imm=12345000 rd=5",
                         i, in_ready, out_valid, out_imm, out_rd);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release_ready: got in_ready=%b, required 1", in_ready);
        end
        q.push_back(mk(64'h2004, 4'd1, 5'd1, 5'd2, 5'd3, 1'b1, 64'd0, 3'd0, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, out_pc} !== {1'b1, 64'h2004}) begin
            fails++;
            $display("FAIL stall_release_accept: got v=%b pc=%h, required v=1 pc=2004", out_valid, out_pc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(32'h402081b3, 64'h3000, mk(64'h3000, 4'd1, 5'd1, 5'd2, 5'd3, 1'b1, 64'd0, 3'd0, 1'b1, 1'b0));
        out_ready = 1'b1; flush = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00512423; in_pc = 64'h3004;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_ready: got in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        tests_run++;
        if ({out_valid, out_pc, out_funct7b5} !== {1'b0, 64'h3000, 1'b1}) begin
            fails++;
            $display("FAIL flush_drop_incoming: got v=%b pc=%h, required v=0 pc=3000", out_valid, out_pc);
        end
        // Flush a held bundle that EX never accepted.
        out_ready = 1'b0;
        send(32'h002081b3, 64'h3008, mk(64'h3008, 4'd1, 5'd1, 5'd2, 5'd3, 1'b1, 64'd0, 3'd0, 1'b0, 1'b0));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(q.pop_back());
        tests_run++;
        if ({out_valid, out_pc} !== {1'b0, 64'h3008}) begin
            fails++;
            $display("FAIL flush_held: got v=%b pc=%h, required v=0 pc=3008", out_valid, out_pc);
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        send(32'hff80a383, 64'h4000, mk(64'h4000, 4'd2, 5'd1, 5'd0, 5'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b1, 1'b0));
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({out_valid, out_pc, out_imm, in_ready} !== {1'b0, RPC, 64'd0, 1'b1}) begin
            fails++;
            $display("FAIL reset_async: got v=%b pc=%h imm=%h, required v=0 pc=%h imm=0", out_valid, out_pc, out_imm, RPC);
        end
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        send(32'h00000000, 64'h5000, mk(64'h5000, 4'd15, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 3'd0, 1'b0, ILL_EN));
        tests_run++;
        if ({out_illegal, out_wen, out_class} !== {ILL_EN, 1'b0, 4'd15}) begin
            fails++;
            $display("FAIL illegal_zero: got ill=%b wen=%b cls=%0d, required ill=%b wen=0 cls=15", out_illegal, out_wen, out_class, ILL_EN);
        end
        send(32'h022081b3, 64'h5004, mk(64'h5004, 4'd1, 5'd1, 5'd2, ILL_EN ? 5'd0 : 5'd3, !ILL_EN, 64'd0, 3'd0, 1'b0, ILL_EN));
        @(posedge clk); #1;
    endtask

    task automatic test_decode_mix();
        logic [31:0] insts[8];
        exp_t        es[8];
        insts[0] = 32'h0013031b; es[0] = mk(64'h6000, 4'd10, 5'd6, 5'd0, 5'd6, 1'b1, 64'd1, 3'd0, 1'b0, 1'b0);
        insts[1] = 32'h00000013; es[1] = mk(64'h6004, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 3'd0, 1'b0, 1'b0);
        insts[2] = 32'hff80a383; es[2] = mk(64'h6008, 4'd2, 5'd1, 5'd0, 5'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b1, 1'b0);
        insts[3] = 32'hfffff517; es[3] = mk(64'h600c, 4'd6, 5'd0, 5'd0, 5'd10, 1'b1, 64'hFFFF_FFFF_FFFF_F000, 3'd7, 1'b1, 1'b0);
        insts[4] = 32'h00008067; es[4] = mk(64'h6010, 4'd8, 5'd1, 5'd0, 5'd0, 1'b0, 64'd0, 3'd0, 1'b0, 1'b0);
        insts[5] = 32'h00000073; es[5] = mk(64'h6014, 4'd9, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 3'd0, 1'b0, 1'b0);
        insts[6] = 32'h402081b3; es[6] = mk(64'h6018, 4'd1, 5'd1, 5'd2, 5'd3, 1'b1, 64'd0, 3'd0, 1'b1, 1'b0);
        insts[7] = 32'h0062823b; es[7] = mk(64'h601c, 4'd11, 5'd5, 5'd6, 5'd4, 1'b1, 64'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(insts[i], es[i].pc, es[i]);
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (q.size() !== 0) begin
            fails++;
            $display("FAIL drain: got %0d bundles outstanding, required 0", q.size());
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_addi();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_illegal();
        test_decode_mix();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
